// File: rtl/case_1_mul_pipe_mac_if.sv
// Operand/result handshake bundle for case_1_mul_pipe_mac.
// master = producer/consumer side, slave = the multiply-accumulate unit.
interface case_1_mul_pipe_mac_if #(
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 9
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  din0_signed;
    logic                  din1_signed;
    logic                  acc;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
    logic                  ovf;

    modport master (
        output in_valid, din0, din1, din0_signed, din1_signed, acc, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, din0_signed, din1_signed, acc, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/case_1_mul_pipe_mac.sv
// Pipelined multiply-accumulate with per-beat signedness and global-stall flow control.
// Define CASE_1_MUL_PIPE_SAT_EN to saturate overflowing results instead of wrapping.
module case_1_mul_pipe_mac #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    case_1_mul_pipe_mac_if.slave  bus
);
    localparam int P = din0_WIDTH + din1_WIDTH + 2;
    localparam int W = dout_WIDTH;
    localparam int F = ((P > W) ? P : W) + 2;

    if (NUM_STAGE < 1 || NUM_STAGE > 8 || W < 2 || W > P + 6 || ID < 0) begin : g_bad_cfg
        $error("case_1_mul_pipe_mac: illegal parameter set");
    end

    typedef struct packed {
        logic         vld;
        logic         sgn;
        logic         acc;
        logic [P-1:0] prod;
    } beat_t;

    logic                adv;
    logic                out_valid_q;
    logic [W-1:0]        dout_q;
    logic                ovf_q;
    logic                prev_sgn_q;

    logic [din0_WIDTH:0] a_ext;
    logic [din1_WIDTH:0] b_ext;
    beat_t               s0;
    beat_t               fin;

    logic [F-1:0]        prev_ext;
    logic [F-1:0]        prod_ext;
    logic [F-1:0]        full;
    logic                ovf_c;
    logic [W-1:0]        res;

    // A single stall signal freezes every stage, so nothing is dropped or duplicated.
    assign adv           = !out_valid_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        a_ext   = {bus.din0_signed & bus.din0[din0_WIDTH-1], bus.din0};
        b_ext   = {bus.din1_signed & bus.din1[din1_WIDTH-1], bus.din1};
        s0      = '0;
        s0.vld  = bus.in_valid;
        s0.sgn  = bus.din0_signed | bus.din1_signed;
        s0.acc  = bus.acc;
        s0.prod = P'($signed(a_ext)) * P'($signed(b_ext));
    end

    if (NUM_STAGE > 1) begin : g_pipe
        localparam int D = NUM_STAGE - 1;
        beat_t pipe_q [D];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                for (int unsigned i = 0; i < D; i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (adv) begin
                pipe_q[0] <= s0;
                for (int unsigned i = 1; i < D; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign fin = pipe_q[D-1];
    end else begin : g_direct
        assign fin = s0;
    end

    // Accumulation happens here against the registered result, so acc beats chain without bubbles.
    always_comb begin
        prev_ext = {{(F-W){prev_sgn_q & dout_q[W-1]}}, dout_q};
        prod_ext = {{(F-P){fin.prod[P-1]}}, fin.prod};
        full     = fin.acc ? (prev_ext + prod_ext) : prod_ext;

        if (fin.sgn) begin
            ovf_c = (|full[F-1:W-1]) && !(&full[F-1:W-1]);
        end else begin
            ovf_c = |full[F-1:W];
        end

`ifdef CASE_1_MUL_PIPE_SAT_EN
        if (ovf_c) begin
            if (fin.sgn) begin
                res = full[F-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                res = full[F-1] ? '0 : '1;
            end
        end else begin
            res = full[W-1:0];
        end
`else
        res = full[W-1:0];
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
            prev_sgn_q  <= 1'b0;
        end else if (adv) begin
            out_valid_q <= fin.vld;
            if (fin.vld) begin
                dout_q     <= res;
                ovf_q      <= ovf_c;
                prev_sgn_q <= fin.sgn;
            end
        end
    end
endmodule

// File: tb/tb_case_1_mul_pipe_mac.sv
// Scoreboard bench for case_1_mul_pipe_mac at default parameters.
module tb_case_1_mul_pipe_mac;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   stalls;

    typedef struct {
        logic [8:0] d;
        logic       o;
        int         ac;
        int         st;
    } exp_t;

    exp_t exp_q[$];

    case_1_mul_pipe_mac_if #(.din0_WIDTH(6), .din1_WIDTH(5), .dout_WIDTH(9)) bus ();

    case_1_mul_pipe_mac #(
        .ID(1), .NUM_STAGE(3), .din0_WIDTH(6), .din1_WIDTH(5), .dout_WIDTH(9)
    ) dut (
        .ap_clk  (clk),
        .ap_rst_n(rst_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every output handshake; latency grows by one per stall cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out: dout=%0h with nothing expected (cycle %0d)", bus.dout, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dout", 32'(bus.dout), 32'(e.d));
                    chk("ovf", 32'(bus.ovf), 32'(e.o));
                    chk("latency", 32'(cyc - e.ac), 32'(3 + stalls - e.st));
                end
            end
            if (bus.out_valid && !bus.out_ready) stalls++;
        end
    end

    task automatic send(input logic [5:0] a, input logic [4:0] b, input logic sa, input logic sb,
                        input logic ac, input logic [8:0] ed, input logic eo);
        int n;
        exp_t e;
        bus.in_valid    = 1'b1;
        bus.din0        = a;
        bus.din1        = b;
        bus.din0_signed = sa;
        bus.din1_signed = sb;
        bus.acc         = ac;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready stuck low got 0 expected 1");
                break;
            end
        end
        if (n <= 200) begin
            e.d  = ed;
            e.o  = eo;
            e.ac = cyc;
            e.st = stalls;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || bus.out_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        stalls          = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.din0        = '0;
        bus.din1        = '0;
        bus.din0_signed = 1'b0;
        bus.din1_signed = 1'b0;
        bus.acc         = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(6'h3D, 5'h05, 1, 1, 0, 9'h1F1, 0);
        drain();
`ifdef CASE_1_MUL_PIPE_SAT_EN
        send(6'h20, 5'h10, 1, 1, 0, 9'h0FF, 1);
        send(6'h3F, 5'h1F, 0, 0, 0, 9'h1FF, 1);
        send(6'h00, 5'h00, 0, 0, 1, 9'h1FF, 0);
`else
        send(6'h20, 5'h10, 1, 1, 0, 9'h000, 1);
        send(6'h3F, 5'h1F, 0, 0, 0, 9'h1A1, 1);
        send(6'h00, 5'h00, 0, 0, 1, 9'h1A1, 0);
`endif
        drain();

        send(6'h02, 5'h03, 1, 1, 0, 9'd6, 0);
        send(6'h04, 5'h05, 1, 1, 1, 9'd26, 0);
        send(6'h3F, 5'h07, 1, 1, 1, 9'd19, 0);
        send(6'h01, 5'h01, 1, 1, 0, 9'd1, 0);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(6'(i + 1), 5'd3, 0, 0, 0, 9'((i + 1) * 3), 0);
                end
            end
            begin
                int n;
                n = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid) break;
                    n++;
                    if (n > 50) break;
                end
                chk("stall_start_seen", 32'(bus.out_valid), 1);
                bus.out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(bus.in_ready), 0);
                    chk("stall_dout_hold", 32'(bus.dout), 3);
                    @(posedge clk);
                end
                #1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                chk("stall_release_in_ready", 32'(bus.in_ready), 1);
            end
        join
        drain();
        chk("stall_cycles", 32'(stalls), 4);

        send(6'h05, 5'h02, 0, 0, 0, 9'd10, 0);
        send(6'h06, 5'h02, 0, 0, 0, 9'd12, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 0);
        chk("async_dout", 32'(bus.dout), 0);
        chk("async_ovf", 32'(bus.ovf), 0);
        chk("async_in_ready", 32'(bus.in_ready), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(bus.out_valid), 0);

        send(6'h02, 5'h03, 0, 0, 1, 9'd6, 0);
        send(6'h3D, 5'h05, 1, 1, 1, 9'h1F7, 0);
        drain();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
